// File: rtl/cheb_series_mac.sv
// Chebyshev series multiply-accumulate stage.
// Walks the T_i coefficient ROM over addresses 0..N_TERMS-1, multiplies each
// returned word by a locally stored series coefficient c_i, accumulates
// y = sum c_i*T_i and presents a rounded, saturated Q1.15 result on a
// valid/ready handshake.
module cheb_series_mac #(
  parameter int N_TERMS = 8,
  parameter int DW      = 16,
  parameter int AW      = 35
) (
  input  logic                       c_clk,
  input  logic                       c_rst,
  input  logic                       c_start,
  input  logic                       i_coef_wr_en,
  input  logic [$clog2(N_TERMS)-1:0] i_coef_addr,
  input  logic [DW-1:0]              i_coef_data,
  output logic [$clog2(N_TERMS)-1:0] o_rom_address,
  output logic                       c_rom_read_en,
  output logic                       c_rom_ce,
  output logic                       c_rom_tri_output,
  input  logic [DW-1:0]              i_rom_data,
  output logic                       o_busy,
  output logic [DW-1:0]              o_y,
  output logic                       o_y_valid,
  input  logic                       i_y_ready,
  output logic                       o_sat
);

  localparam int ADW = $clog2(N_TERMS);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_ROUND = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  localparam logic [ADW-1:0]          LAST_CNT  = ADW'(N_TERMS - 1);
  localparam logic [ADW-1:0]          DRAIN_END = ADW'(1);
  localparam logic signed [AW-1:0]    HALF_LSB  = AW'(2 ** (DW - 2));
  localparam logic signed [AW-DW:0]   R_MAX     = (AW-DW+1)'(2 ** (DW - 1) - 1);
  localparam logic signed [AW-DW:0]   R_MIN     = (AW-DW+1)'(-(2 ** (DW - 1)));

  logic [2:0]              state_q, state_d;
  logic [ADW-1:0]          cnt_q, cnt_d;
  logic [DW-1:0]           coef_q [N_TERMS];
  logic [ADW-1:0]          rom_addr_q;
  logic                    rom_en_q;

  logic signed [DW-1:0]    d1_q, k1_q;
  logic                    v1_q;
  logic signed [2*DW-1:0]  p2_q;
  logic                    v2_q;
  logic signed [AW-1:0]    acc_q;
  logic signed [AW-1:0]    p_ext;
  logic signed [AW-1:0]    acc_rnd;
  logic signed [AW-DW:0]   r;

  logic [DW-1:0]           y_rnd;
  logic                    sat_rnd;
  logic [DW-1:0]           y_q;
  logic                    sat_q;
  logic                    valid_q;

  logic                    start_acc;

  // Next-state and term/drain counter sequencing.
  always_comb begin
    // NOTE: every variable written here gets a default first so no path leaves it unassigned, which would infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    start_acc = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (c_start) begin
          state_d   = S_RUN;
          cnt_d     = '0;
          start_acc = 1'b1;
        end
      end
      S_RUN: begin
        if (cnt_q == LAST_CNT) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADW'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == DRAIN_END) begin
          state_d = S_ROUND;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADW'(1);
        end
      end
      S_ROUND: state_d = S_HOLD;
      S_HOLD:  if (i_y_ready) state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and registered ROM bus controls (released outside RUN).
  always_ff @(posedge c_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (c_rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rom_addr_q <= '0;
      rom_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rom_addr_q <= (state_d == S_RUN) ? cnt_d : '0;
      rom_en_q   <= (state_d == S_RUN);
    end
  end

  // Coefficient bank; writes are accepted only while idle.
  always_ff @(posedge c_clk) begin
    // NOTE: the bank is a small register file that must read back zero after reset, so it is cleared explicitly rather than left as an uninitialised memory.
    if (c_rst) begin
      for (int i = 0; i < N_TERMS; i++) coef_q[i] <= '0;
    end else if (i_coef_wr_en && (state_q == S_IDLE)) begin
      coef_q[i_coef_addr] <= i_coef_data;
    end
  end

  // Stage 1: capture ROM word and matching coefficient while the ROM is enabled.
  always_ff @(posedge c_clk) begin
    if (c_rst) begin
      d1_q <= '0;
      k1_q <= '0;
      v1_q <= 1'b0;
    end else begin
      v1_q <= (state_q == S_RUN);
      if (state_q == S_RUN) begin
        d1_q <= i_rom_data;
        k1_q <= coef_q[cnt_q];
      end
    end
  end

  // Stage 2: Q1.15 x Q1.15 -> Q2.30 signed product.
  always_ff @(posedge c_clk) begin
    if (c_rst) begin
      p2_q <= '0;
      v2_q <= 1'b0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) p2_q <= d1_q * k1_q;
    end
  end

  assign p_ext = {{(AW - 2*DW){p2_q[2*DW-1]}}, p2_q};

  // Stage 3: accumulator, cleared on an accepted start.
  always_ff @(posedge c_clk) begin
    if (c_rst) begin
      acc_q <= '0;
    end else if (start_acc) begin
      acc_q <= '0;
    end else if (v2_q) begin
      acc_q <= acc_q + p_ext;
    end
  end

  // Round half up to Q1.15 (drop 15 fraction bits) and saturate to 16 bits.
  assign acc_rnd = acc_q + HALF_LSB;
  assign r       = acc_rnd[AW-1:DW-1];

  always_comb begin
    y_rnd   = r[DW-1:0];
    sat_rnd = 1'b0;
    if (r > R_MAX) begin
      y_rnd   = {1'b0, {(DW-1){1'b1}}};
      sat_rnd = 1'b1;
    end else if (r < R_MIN) begin
      y_rnd   = {1'b1, {(DW-1){1'b0}}};
      sat_rnd = 1'b1;
    end
  end

  // Result register and handshake: load in ROUND, hold until accepted.
  always_ff @(posedge c_clk) begin
    if (c_rst) begin
      y_q     <= '0;
      sat_q   <= 1'b0;
      valid_q <= 1'b0;
    end else if (state_q == S_ROUND) begin
      y_q     <= y_rnd;
      sat_q   <= sat_rnd;
      valid_q <= 1'b1;
    end else if ((state_q == S_HOLD) && i_y_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign o_rom_address    = rom_addr_q;
  assign c_rom_ce         = rom_en_q;
  assign c_rom_read_en    = rom_en_q;
  assign c_rom_tri_output = ~rom_en_q;
  assign o_busy           = (state_q != S_IDLE);
  assign o_y              = y_q;
  assign o_sat            = sat_q;
  assign o_y_valid        = valid_q;

endmodule

// File: tb/tb_cheb_series_mac.sv
// Self-checking bench for cheb_series_mac: a cycle-phase model of the
// sequencer plus a plain-arithmetic series evaluator, compared every cycle,
// and directed scenarios with hand-computed literal results.
`timescale 1ns/1ps
module tb_cheb_series_mac;

  logic        c_clk = 1'b0;
  logic        c_rst;
  logic        c_start;
  logic        i_coef_wr_en;
  logic [2:0]  i_coef_addr;
  logic [15:0] i_coef_data;
  logic [2:0]  o_rom_address;
  logic        c_rom_read_en;
  logic        c_rom_ce;
  logic        c_rom_tri_output;
  logic [15:0] i_rom_data;
  logic        o_busy;
  logic [15:0] o_y;
  logic        o_y_valid;
  logic        i_y_ready;
  logic        o_sat;

  logic [15:0] rom [8];

  cheb_series_mac dut (
    .c_clk            (c_clk),
    .c_rst            (c_rst),
    .c_start          (c_start),
    .i_coef_wr_en     (i_coef_wr_en),
    .i_coef_addr      (i_coef_addr),
    .i_coef_data      (i_coef_data),
    .o_rom_address    (o_rom_address),
    .c_rom_read_en    (c_rom_read_en),
    .c_rom_ce         (c_rom_ce),
    .c_rom_tri_output (c_rom_tri_output),
    .i_rom_data       (i_rom_data),
    .o_busy           (o_busy),
    .o_y              (o_y),
    .o_y_valid        (o_y_valid),
    .i_y_ready        (i_y_ready),
    .o_sat            (o_sat)
  );

  // ROM model: combinational from address; junk on the bus when disabled.
  assign i_rom_data = c_rom_ce ? rom[o_rom_address] : 16'hDEAD;

  always #5 c_clk = ~c_clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_phase = -1 when idle, else the number of edges since the accepted start
  // (0..10 computing, 11 = result presented).
  int                 m_phase = -1;
  logic signed [15:0] m_coef [8];
  logic [15:0]        m_y   = 16'h0000;
  logic               m_sat = 1'b0;
  logic [15:0]        pend_y;
  logic               pend_sat;
  logic               m_act;

  function automatic void series(output logic [15:0] y, output logic s);
    longint acc = 0;
    longint rr;
    for (int i = 0; i < 8; i++)
      acc += longint'(m_coef[i]) * longint'($signed(rom[i]));
    rr = (acc + 64'sd16384) >>> 15;
    if (rr > 32767) begin
      y = 16'h7FFF; s = 1'b1;
    end else if (rr < -32768) begin
      y = 16'h8000; s = 1'b1;
    end else begin
      y = rr[15:0]; s = 1'b0;
    end
  endfunction

  always @(posedge c_clk) begin
    if (c_rst) begin
      m_phase = -1;
      for (int i = 0; i < 8; i++) m_coef[i] = 16'sh0000;
      m_y   = 16'h0000;
      m_sat = 1'b0;
    end else if (m_phase < 0) begin
      if (i_coef_wr_en) m_coef[i_coef_addr] = i_coef_data;
      if (c_start) begin
        m_phase = 0;
        series(pend_y, pend_sat);
      end
    end else if (m_phase < 11) begin
      m_phase++;
      if (m_phase == 11) begin
        m_y   = pend_y;
        m_sat = pend_sat;
      end
    end else if (i_y_ready) begin
      m_phase = -1;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge c_clk) begin
    if (cmp_en) begin
      m_act = (m_phase >= 0) && (m_phase <= 7);
      check("busy",     o_busy,           m_phase >= 0);
      check("rom_ce",   c_rom_ce,         m_act);
      check("rom_rd",   c_rom_read_en,    m_act);
      check("rom_tri",  c_rom_tri_output, !m_act);
      check("rom_addr", o_rom_address,    m_act ? 3'(m_phase) : 3'd0);
      check("y_valid",  o_y_valid,        m_phase == 11);
      check("y",        o_y,              m_y);
      if (m_phase == 11) check("sat", o_sat, m_sat);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge c_clk);
  endtask

  task automatic write_coef(input int a, input logic [15:0] v);
    i_coef_wr_en = 1'b1;
    i_coef_addr  = 3'(a);
    i_coef_data  = v;
    tick();
    i_coef_wr_en = 1'b0;
  endtask

  task automatic set_all_coef(input logic [15:0] v);
    for (int i = 0; i < 8; i++) write_coef(i, v);
  endtask

  task automatic set_all_rom(input logic [15:0] v);
    for (int i = 0; i < 8; i++) rom[i] = v;
  endtask

  task automatic pulse_start();
    c_start = 1'b1;
    tick();
    c_start = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!o_y_valid && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) check("valid_timeout", o_y_valid, 1'b1);
  endtask

  task automatic accept();
    i_y_ready = 1'b1;
    tick();
    i_y_ready = 1'b0;
    check("accept_valid_drop", o_y_valid, 1'b0);
    check("accept_idle",       o_busy,    1'b0);
  endtask

  task automatic run_expect(input string name, input logic [15:0] ey, input logic es);
    int n;
    pulse_start();
    wait_valid(n);
    check({name, "_latency"}, n, 11);
    check({name, "_y"},       o_y, ey);
    check({name, "_sat"},     o_sat, es);
    accept();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int n;
    int ce_cnt;
    int vcnt;

    c_rst        = 1'b1;
    c_start      = 1'b0;
    i_coef_wr_en = 1'b0;
    i_coef_addr  = 3'd0;
    i_coef_data  = 16'h0000;
    i_y_ready    = 1'b0;
    set_all_rom(16'h0000);

    tick();
    cmp_en = 1'b1;
    tick();
    // Reset state.
    check("rst_busy",  o_busy,           1'b0);
    check("rst_ce",    c_rom_ce,         1'b0);
    check("rst_rd",    c_rom_read_en,    1'b0);
    check("rst_tri",   c_rom_tri_output, 1'b1);
    check("rst_addr",  o_rom_address,    3'd0);
    check("rst_valid", o_y_valid,        1'b0);
    check("rst_y",     o_y,              16'h0000);
    check("rst_sat",   o_sat,            1'b0);
    c_rst = 1'b0;
    tick();

    // Latency / bus timing: c0 = 0.5, T0 = 0x7FFF -> 0x4000.
    set_all_rom(16'h2345);
    rom[0] = 16'h7FFF;
    write_coef(0, 16'h4000);
    pulse_start();
    ce_cnt = 0;
    for (int k = 0; k < 11; k++) begin
      if (c_rom_ce) ce_cnt++;
      if (k == 7) check("bus_addr_last", o_rom_address, 3'd7);
      if (k == 8) check("bus_tri_after_E8", c_rom_tri_output, 1'b1);
      tick();
    end
    check("lat_valid",  o_y_valid, 1'b1);
    check("lat_y",      o_y,       16'h4000);
    check("lat_sat",    o_sat,     1'b0);
    check("lat_ce_cnt", ce_cnt,    8);
    accept();

    // Full series.
    set_all_rom(16'h7FFF);
    set_all_coef(16'h1000);
    run_expect("ser_eighth", 16'h7FFF, 1'b0);
    set_all_coef(16'h7FFF);
    run_expect("ser_posmax", 16'h7FFF, 1'b1);
    set_all_coef(16'h8000);
    run_expect("ser_negmax", 16'h8000, 1'b1);

    // Backpressure with ignored starts.
    pulse_start();
    wait_valid(n);
    for (int k = 0; k < 5; k++) begin
      c_start = (k == 1 || k == 3);
      tick();
      check("bp_y",     o_y,       16'h8000);
      check("bp_sat",   o_sat,     1'b1);
      check("bp_busy",  o_busy,    1'b1);
      check("bp_valid", o_y_valid, 1'b1);
    end
    c_start = 1'b0;
    accept();
    tick();
    check("bp_no_queued_run", o_busy, 1'b0);

    // Reset mid-run at E4.
    set_all_coef(16'h1000);
    pulse_start();
    repeat (3) tick();
    c_rst = 1'b1;
    tick();
    check("mrst_ce",    c_rom_ce,         1'b0);
    check("mrst_rd",    c_rom_read_en,    1'b0);
    check("mrst_tri",   c_rom_tri_output, 1'b1);
    check("mrst_busy",  o_busy,           1'b0);
    check("mrst_valid", o_y_valid,        1'b0);
    c_rst = 1'b0;
    vcnt = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (o_y_valid) vcnt++;
    end
    check("mrst_no_result", vcnt, 0);
    run_expect("mrst_bank_zero", 16'h0000, 1'b0);

    // Coefficient write while busy is dropped; in idle it takes effect.
    pulse_start();
    tick();
    i_coef_wr_en = 1'b1;
    i_coef_addr  = 3'd3;
    i_coef_data  = 16'h7FFF;
    tick();
    i_coef_wr_en = 1'b0;
    wait_valid(n);
    check("busywr_y", o_y, 16'h0000);
    accept();
    write_coef(3, 16'h7FFF);
    run_expect("idlewr", 16'h7FFE, 1'b0);

    // Back-to-back with ready tied high.
    write_coef(3, 16'h0000);
    write_coef(0, 16'h4000);
    i_y_ready = 1'b1;
    c_start   = 1'b1;
    tick();
    for (int k = 0; k < 28; k++) begin
      check("b2b_valid_slot", o_y_valid, (k == 11 || k == 24));
      if (k == 11 || k == 24) check("b2b_y", o_y, 16'h4000);
      if (k == 12) check("b2b_idle_gap", o_busy, 1'b0);
      if (k == 13) c_start = 1'b0;
      tick();
    end
    i_y_ready = 1'b0;
    check("b2b_end_idle", o_busy, 1'b0);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
